// File: rtl/rom_player.sv
// rom_player: registered lookup ROM with single-word random reads and an
// autonomous playback sequencer that streams the whole table in address
// order over a valid/ready output, one-shot or looping.
//
// Table contents: word[a] = (a + OFFSET) mod 2^DATA_W. The address is
// zero-extended or truncated to DATA_W bits before the add.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   rd_en      random-read request (honoured only in IDLE)
//   rd_adr     random-read address
//   start      begin playback from address 0 (honoured only in IDLE)
//   stop       abort playback
//   loop       1 = wrap to address 0 after the last word, 0 = one-shot
//   out_ready  consumer accepts the current word
//   data       registered ROM word
//   adr_out    address of the word currently on data
//   data_valid data/adr_out hold a word not yet accepted
//   busy       sequencer is playing
//   done       one-cycle pulse after a one-shot playback completes
//
// Output handshake: a word transfers in any cycle where data_valid=1 and
// out_ready=1. While data_valid=1 and out_ready=0, data and adr_out hold
// stable. out_ready is ignored while data_valid=0. The output register is
// "free" (may be reloaded this cycle) when data_valid=0 or the current word
// is being accepted.
module rom_player #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int OFFSET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_adr,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] adr_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADR = '1;
  localparam logic [ADDR_W-1:0] ONE_ADR  = ADDR_W'(1);

  state_t state;

  // ROM content: computed in 32 bits, then truncated so the sum wraps
  // modulo 2^DATA_W and narrow DATA_W simply drops upper address bits.
  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [31:0] sum;
    sum = 32'(a) + 32'(OFFSET);
    return sum[DATA_W-1:0];
  endfunction

  logic              accept;
  logic              reg_free;
  logic [ADDR_W-1:0] next_adr;

  assign accept   = data_valid & out_ready;
  assign reg_free = ~data_valid | out_ready;
  assign next_adr = adr_out + ONE_ADR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      data       <= '0;
      adr_out    <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // start wins over rd_en; both are dropped when the register is
          // occupied by a word the consumer has not taken yet.
          if (start && reg_free) begin
            state      <= S_PLAY;
            busy       <= 1'b1;
            data       <= word_of('0);
            adr_out    <= '0;
            data_valid <= 1'b1;
          end else if (rd_en && reg_free) begin
            data       <= word_of(rd_adr);
            adr_out    <= rd_adr;
            data_valid <= 1'b1;
          end else if (accept) begin
            data_valid <= 1'b0;
          end
        end

        S_PLAY: begin
          // stop discards the pending word and does not raise done.
          if (stop) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            data_valid <= 1'b0;
          end else if (accept) begin
            if (adr_out != LAST_ADR) begin
              data    <= word_of(next_adr);
              adr_out <= next_adr;
            end else if (loop) begin
              data    <= word_of('0);
              adr_out <= '0;
            end else begin
              state      <= S_DONE;
              data_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // done was raised on entry; this cycle only returns to IDLE.
          state <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_player.sv
module tb_rom_player;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: default parameters ----------------
  logic       rd_en = 0, start = 0, stop = 0, loop = 0, out_ready = 0;
  logic [2:0] rd_adr = '0;
  logic [3:0] data;
  logic [2:0] adr_out;
  logic       data_valid, busy, done;

  rom_player dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_adr(rd_adr),
    .start(start), .stop(stop), .loop(loop), .out_ready(out_ready),
    .data(data), .adr_out(adr_out), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  // ---------------- DUT B: ADDR_W=4, DATA_W=3, OFFSET=6 ----------------
  logic       rd_en2 = 0, out_ready2 = 0;
  logic [3:0] rd_adr2 = '0;
  logic [2:0] data2;
  logic [3:0] adr_out2;
  logic       data_valid2, busy2, done2;

  rom_player #(.ADDR_W(4), .DATA_W(3), .OFFSET(6)) dut2 (
    .clk(clk), .reset(reset), .rd_en(rd_en2), .rd_adr(rd_adr2),
    .start(1'b0), .stop(1'b0), .loop(1'b0), .out_ready(out_ready2),
    .data(data2), .adr_out(adr_out2), .data_valid(data_valid2),
    .busy(busy2), .done(done2)
  );

  // ---------------- counters / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];   // {adr_out, data} of DUT A in acceptance order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard sample at the falling edge: a word that is valid with
  // out_ready high transfers on the next rising edge, so pop and compare.
  task automatic sb_sample();
    logic [6:0] e;
    if (!reset && data_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", {25'd0, adr_out, data}, 32'h7fff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", {25'd0, adr_out, data}, {25'd0, e});
      end
    end
  endtask

  // One clock: scoreboard at negedge, then settle 1 ns past the posedge.
  task automatic tick();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] w(input int a);
    logic [2:0] aa;
    aa = 3'(a);
    return {aa, 4'(a + 1)};   // default table: address a holds a+1
  endfunction

  // ---------------- vector table for random reads ----------------
  typedef struct {
    logic       rd_en;
    logic [2:0] adr;
    logic       ready;
    logic [3:0] exp_data;
    logic [2:0] exp_adr;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[9];

  int acc;
  int busy_cnt;
  int done_cnt;
  logic [3:0] p5_adr[4];
  logic [2:0] p5_exp[4];

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 3'(i), 1'b1, 4'(i + 1), 3'(i), 1'b1};
    vecs[8] = '{1'b0, 3'd0, 1'b1, 4'd8, 3'd7, 1'b0};
    p5_adr = '{4'd0, 4'd1, 4'd2, 4'd15};
    p5_exp = '{3'd6, 3'd7, 3'd0, 3'd5};

    // ---- reset ----
    tick(); tick();
    check("rst_data", 32'(data), 0);
    check("rst_adr", 32'(adr_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    tick();

    // ---- 1: random reads 0..7 back-to-back ----
    foreach (vecs[i]) begin
      rd_en = vecs[i].rd_en; rd_adr = vecs[i].adr; out_ready = vecs[i].ready;
      if (vecs[i].rd_en) exp_q.push_back({vecs[i].exp_adr, vecs[i].exp_data});
      tick();
      check("rd_data", 32'(data), 32'(vecs[i].exp_data));
      check("rd_adr", 32'(adr_out), 32'(vecs[i].exp_adr));
      check("rd_valid", 32'(data_valid), 32'(vecs[i].exp_valid));
      check("rd_busy", 32'(busy), 0);
    end
    rd_en = 0; out_ready = 0;

    // ---- 2: read stalled 3 cycles, second read ignored ----
    rd_en = 1; rd_adr = 3'd5; exp_q.push_back(w(5));
    tick();
    check("stall_data0", 32'(data), 6);
    rd_adr = 3'd2;                 // rd_en still high: must be dropped
    tick();
    check("stall_data1", 32'(data), 6);
    check("stall_adr1", 32'(adr_out), 5);
    rd_en = 0;
    tick();
    check("stall_data2", 32'(data), 6);
    check("stall_valid2", 32'(data_valid), 1);
    out_ready = 1;
    tick();
    check("stall_after_accept_valid", 32'(data_valid), 0);
    out_ready = 0;
    tick();

    // ---- 3: one-shot playback at full rate ----
    loop = 0; out_ready = 1; start = 1;
    for (int a = 0; a < 8; a++) exp_q.push_back(w(a));
    busy_cnt = 0;
    tick();
    start = 0;
    for (int k = 0; k < 8; k++) begin
      check("play_data", 32'(data), 32'(k + 1));
      check("play_adr", 32'(adr_out), 32'(k));
      check("play_done_low", 32'(done), 0);
      if (busy) busy_cnt++;
      tick();
    end
    check("play_end_valid", 32'(data_valid), 0);
    check("play_end_done", 32'(done), 1);
    check("play_end_busy", 32'(busy), 0);
    check("play_busy_cycles", 32'(busy_cnt), 8);
    tick();
    check("play_done_pulse_end", 32'(done), 0);
    out_ready = 0;
    tick();

    // ---- 4: looping with a stalling consumer, stop at adr 3 ----
    loop = 1; start = 1;
    for (int a = 0; a < 8; a++) exp_q.push_back(w(a));
    for (int a = 0; a < 3; a++) exp_q.push_back(w(a));
    tick();
    start = 0;
    acc = 0;
    for (int c = 0; c < 100 && acc < 11; c++) begin
      out_ready = c[0];
      if (data_valid && out_ready) acc++;
      tick();
    end
    out_ready = 0;
    check("loop_accepted_words", 32'(acc), 11);
    check("loop_adr_before_stop", 32'(adr_out), 3);
    check("loop_data_before_stop", 32'(data), 4);
    stop = 1;
    tick();
    stop = 0;
    check("stop_valid", 32'(data_valid), 0);
    check("stop_busy", 32'(busy), 0);
    done_cnt = 32'(done);
    for (int k = 0; k < 3; k++) begin
      tick();
      done_cnt += 32'(done);
    end
    check("stop_no_done", 32'(done_cnt), 0);
    check("loop_queue_drained", 32'(exp_q.size()), 0);
    loop = 0;

    // ---- 5: parameter wrap on the second instance ----
    out_ready2 = 1;
    for (int i = 0; i < 4; i++) begin
      rd_en2 = 1; rd_adr2 = p5_adr[i];
      tick();
      check("p5_data", 32'(data2), 32'(p5_exp[i]));
      check("p5_adr", 32'(adr_out2), 32'(p5_adr[i]));
      check("p5_valid", 32'(data_valid2), 1);
    end
    rd_en2 = 0;
    tick();
    check("p5_valid_clear", 32'(data_valid2), 0);
    out_ready2 = 0;

    // ---- 6: async reset mid-playback ----
    loop = 1; out_ready = 1; start = 1;
    exp_q.push_back(w(0)); exp_q.push_back(w(1));
    tick();
    start = 0;
    tick(); tick();           // words 0,1 accepted; adr 2 now on output
    out_ready = 0;
    check("pre_reset_busy", 32'(busy), 1);
    check("pre_reset_data", 32'(data), 3);
    #2 reset = 1'b1;          // between clock edges
    #1;
    check("async_rst_data", 32'(data), 0);
    check("async_rst_adr", 32'(adr_out), 0);
    check("async_rst_valid", 32'(data_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    #1 reset = 1'b0;
    tick();
    loop = 0; out_ready = 1; start = 1;
    for (int a = 0; a < 8; a++) exp_q.push_back(w(a));
    tick();
    start = 0;
    check("replay_data", 32'(data), 1);
    check("replay_adr", 32'(adr_out), 0);
    check("replay_busy", 32'(busy), 1);
    for (int k = 0; k < 8; k++) tick();
    check("replay_done", 32'(done), 1);
    out_ready = 0;
    tick();
    check("final_queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_player.md
Name: rom_player

Overview:
- Parametrised, registered lookup ROM with two access modes: single-word random reads and an autonomous playback sequencer.
- Playback streams the whole table in address order over a valid/ready output, with one-shot or looping operation.
- Sits between control logic (address/start/stop) and a downstream consumer (display driver, DAC, pattern checker) that may stall.
- With default parameters the table contents are the existing 8x4 pattern: addresses 0..7 return 1..8.

Parameters:
ADDR_W  3  address width; depth = 2^ADDR_W words
DATA_W  4  word width
OFFSET  1  content rule: word[a] = (a + OFFSET) mod 2^DATA_W

Ports:
clk        input   1       rising-edge clock
reset      input   1       asynchronous, active-high reset
rd_en      input   1       random-read request (honoured only in IDLE)
rd_adr     input   ADDR_W  random-read address
start      input   1       begin playback from address 0 (honoured only in IDLE)
stop       input   1       abort playback
loop       input   1       1 = wrap to address 0 after last word; 0 = one-shot
out_ready  input   1       consumer accepts the current word
data       output  DATA_W  registered ROM word
adr_out    output  ADDR_W  address of the word currently on data
data_valid output  1       data/adr_out hold a word not yet accepted
busy       output  1       FSM in PLAY
done       output  1       one-cycle pulse after one-shot playback completes

Behaviour:
- Reset (async, active-high): state IDLE; data=0, adr_out=0, data_valid=0, busy=0, done=0.
- Content arithmetic:
  - Address zero-extended (or truncated) to DATA_W, then OFFSET added.
  - Sum is truncated to DATA_W bits (wraps; no saturation).
  - Content is combinational from the address; all outputs are registered.
- Output handshake:
  - A word is accepted in a cycle where data_valid=1 and out_ready=1.
  - While data_valid=1 and out_ready=0, data and adr_out hold stable.
  - out_ready has no effect when data_valid=0.
- FSM states: IDLE, PLAY, DONE.
- IDLE:
  - Output register is free when data_valid=0, or data_valid=1 and out_ready=1.
  - start=1 and register free: next cycle state=PLAY, busy=1, data=word[0], adr_out=0, data_valid=1.
  - Otherwise, rd_en=1 and register free: next cycle data=word[rd_adr], adr_out=rd_adr, data_valid=1; state stays IDLE. Read latency is 1 cycle.
  - start takes priority over rd_en when both are high.
  - start or rd_en while the register is not free: ignored (not queued).
  - Register free with no request: data_valid clears on acceptance.
  - stop ignored in IDLE.
- PLAY:
  - stop=1: next cycle state=IDLE, busy=0, data_valid=0, done stays 0. stop takes priority over acceptance/advance.
  - Acceptance with adr_out < 2^ADDR_W-1: load word[adr_out+1], data_valid stays 1.
  - Acceptance with adr_out = 2^ADDR_W-1 and loop=1: load word[0], adr_out=0, stay in PLAY. loop is sampled in that cycle.
  - Acceptance at the last address with loop=0: next cycle state=DONE, data_valid=0, busy=0.
  - No acceptance: hold.
  - rd_en and start ignored in PLAY.
  - Sustained out_ready=1 gives one word per cycle.
- DONE: done=1 for exactly this cycle; unconditional transition to IDLE. All inputs ignored.
- Reset mid-operation: immediate return to reset values; any pending word is discarded.
- ADDR_W=1 and DATA_W < ADDR_W must work: the truncation rules apply.

Test Plan:
1. Defaults: reset, then rd_en with rd_adr=0..7, out_ready=1 -> data = 1..8, each one cycle after request; adr_out matches; busy=0.
2. Random read with out_ready=0 for 3 cycles at rd_adr=5 -> data=6 holds for 3 cycles; a second rd_en (adr 2) during the stall is ignored; after acceptance data_valid=0.
3. One-shot playback, loop=0, out_ready=1:
   - start -> words 1,2,...,8 on consecutive cycles, adr_out 0..7.
   - Then data_valid=0 and done=1 for one cycle; busy high for 8 cycles.
4. Loop with stalls:
   - loop=1, out_ready toggling 1/0 -> sequence 1..8,1,2,... with no word skipped or duplicated.
   - stop asserted while adr_out=3 -> next cycle IDLE, data_valid=0, done never asserts.
5. Parameter/wrap: ADDR_W=4, DATA_W=3, OFFSET=6 -> address 0 gives 6, 1 gives 7, 2 gives 0, 15 gives 5 (mod 8).
6. Async reset asserted mid-PLAY (between clock edges) -> outputs zero immediately without a clock edge; after release, start replays from data=1.
